crc8_frame_ctrl: RTL
====================

# crc8_frame_ctrl

Frame-level sequencer for the team's bit-serial CRC-8 datapath (polynomial 0x2F, x^8+x^5+x^3+x^2+x+1, seed 0xFF, MSB-first, no reflection, no final XOR). It accepts bytes over a valid/ready stream and serializes each byte one bit per clock into an internal CRC-8 bit-update stage. It tracks frame length and presents the final CRC on a held output handshake. It sits between a byte-wide packet source and the link framer that appends or verifies the CRC.

## Interface
- LEN_W, 16: width of the frame byte counter.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- abort  in  1  sync abort: drop the current frame, reseed the CRC, and return to IDLE.
- s_valid  in  1  input byte valid.
- s_ready  out  1  block can accept a byte.
- s_data  in  8  input byte, serialized MSB first.
- s_last  in  1  the byte is the final data byte of the frame.
- crc_valid  out  1  final CRC is presented.
- crc_ready  in  1  consumer accepts the CRC.
- crc_out  out  8  CRC over all data bytes of the frame.
- crc_ok  out  1  received CRC matched; meaningful only when crc_valid is high.
- byte_cnt  out  LEN_W  data bytes accepted in the current or just-finished frame; saturates at all-ones.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, SHIFT, CHK (only with CRC8_CHECK_EN), DONE.
- CRC bit update, applied once per SHIFT cycle with din = sh[7]:
  - fb = crc[7]^din
  - next = {crc[6], crc[5], crc[4]^fb, crc[3], crc[2]^fb, crc[1]^fb, crc[0]^fb, fb}
- IDLE:
  - s_ready=1.
  - On s_valid&s_ready: sh<=s_data, last_q<=s_last, bit_cnt<=0, byte_cnt<=byte_cnt+1 (saturating), go to SHIFT.
- SHIFT:
  - s_ready=0.
  - Each cycle: crc<=next, sh<=sh<<1, bit_cnt++.
  - On the cycle with bit_cnt==7: if last_q, go to CHK (if enabled) or DONE; otherwise go to IDLE with crc held.
- DONE:
  - crc_valid=1 and crc_out=crc, both held stable until crc_ready.
  - On crc_valid&crc_ready: crc<=0xFF, byte_cnt<=0, go to IDLE.
  - s_ready=0.
- crc_out equals the crc register in every state.
- Reset values: state=IDLE, crc=0xFF, sh=0, bit_cnt=0, byte_cnt=0, last_q=0.
  - Resulting outputs: s_ready=1, crc_valid=0, crc_out=0xFF, crc_ok=0, busy=0.
- abort:
  - Has the same effect as reset on all state, from any state including mid-SHIFT and DONE.
  - Takes priority over every handshake in the same cycle.
  - A byte offered in the abort cycle is not accepted.
- rst has priority over abort.
- A frame of one byte is legal. Zero-length frames cannot occur, since s_last rides on a data byte.

## Timing
- Byte accepted at edge N: SHIFT occupies edges N+1..N+8. The block is back in IDLE, with s_ready=1, in the cycle after edge N+8.
  - Throughput: one byte per 9 cycles maximum.
- Last byte accepted at edge N, without CRC8_CHECK_EN: crc_valid=1 from edge N+8 onward.
- crc_valid stays high until the handshake completes. If crc_ready is already high, DONE lasts exactly one cycle.
- The first s_ready of the next frame is one cycle after the crc handshake edge.
- byte_cnt updates on the accept edge. It keeps the frame's final count through DONE and clears on the crc handshake.

## Configuration
- CRC8_CHECK_EN defined:
  - After the last data byte's SHIFT, the block enters CHK with s_ready=1.
  - The next accepted byte is the received CRC. It is compared with crc, and the compare result is registered into crc_ok.
  - The block then goes to DONE. s_last on the CRC byte is ignored, and the CRC byte does not count in byte_cnt.
  - crc_ok clears on the crc handshake, abort, and rst.
- CRC8_CHECK_EN undefined:
  - CHK state and compare logic are absent; crc_ok is tied to 0.
  - crc_valid follows the last data byte's SHIFT directly.

## Test plan
- Reset: assert rst for 2 cycles, then release -> s_ready=1, crc_valid=0, crc_out=0xFF, byte_cnt=0, busy=0.
- One-byte frame 0x00 with s_last, crc_ready=1 -> crc_valid exactly 8 cycles after the accept edge, crc_out=0x42, byte_cnt=1. Repeat with 0xFF -> crc_out=0x00.
- Two-byte frame 0x00, 0x00 (s_last on the second) -> crc_out=0xB8, byte_cnt=2. s_ready is low for the 8 cycles after each accept.
- Backpressure: hold crc_ready=0 for 5 cycles -> crc_valid and crc_out stay stable and s_ready=0. Raising crc_ready completes the handshake, and s_ready=1 the next cycle with the CRC reseeded.
- Abort mid-SHIFT on bit 3 of byte 0x00, then send frame 0xFF -> crc_out=0x00. This proves the reseed.
- CRC8_CHECK_EN only:
  - Frame 0x00 followed by check byte 0x42 -> crc_ok=1, byte_cnt=1.
  - Frame 0x00 followed by check byte 0x43 -> crc_ok=0.

Source files
------------

// File: rtl/crc8_frame_ctrl.sv
// Byte-stream CRC-8 (poly 0x2F, seed 0xFF, MSB-first) frame sequencer with a held CRC handshake.
// Optional received-CRC compare stage is enabled with the CRC8_CHECK_EN macro.
module crc8_frame_ctrl #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             crc_valid,
  input  logic             crc_ready,
  output logic [7:0]       crc_out,
  output logic             crc_ok,
  output logic [LEN_W-1:0] byte_cnt,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for a data byte
  // SHIFT | serializing one byte into the CRC, 8 cycles
  // CHK   | waiting for the received CRC byte (CRC8_CHECK_EN only)
  // DONE  | final CRC presented until crc_ready
`ifdef CRC8_CHECK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, CHK, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t      state;
  logic [7:0]  crc;
  logic [7:0]  sh;
  logic [2:0]  bit_cnt;
  logic        last_q;

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic din);
    logic fb;
    fb = c[7] ^ din;
    return {c[6], c[5], c[4] ^ fb, c[3], c[2] ^ fb, c[1] ^ fb, c[0] ^ fb, fb};
  endfunction

  assign crc_out = crc;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state     <= IDLE;
      crc       <= 8'hFF;
      sh        <= 8'h00;
      bit_cnt   <= 3'd0;
      byte_cnt  <= '0;
      last_q    <= 1'b0;
      s_ready   <= 1'b1;
      crc_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef CRC8_CHECK_EN
      crc_ok    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            sh      <= s_data;
            last_q  <= s_last;
            bit_cnt <= 3'd0;
            if (byte_cnt != {LEN_W{1'b1}})
              byte_cnt <= byte_cnt + 1'b1;
            state   <= SHIFT;
            s_ready <= 1'b0;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          crc     <= crc_step(crc, sh[7]);
          sh      <= {sh[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (last_q) begin
`ifdef CRC8_CHECK_EN
              state     <= CHK;
              s_ready   <= 1'b1;
`else
              state     <= DONE;
              crc_valid <= 1'b1;
`endif
            end else begin
              // Mid-frame byte done: keep the running CRC and take the next byte.
              state   <= IDLE;
              s_ready <= 1'b1;
              busy    <= 1'b0;
            end
          end
        end
`ifdef CRC8_CHECK_EN
        CHK: begin
          if (s_valid) begin
            crc_ok    <= (s_data == crc);
            state     <= DONE;
            s_ready   <= 1'b0;
            crc_valid <= 1'b1;
          end
        end
`endif
        DONE: begin
          if (crc_ready) begin
            crc       <= 8'hFF;
            byte_cnt  <= '0;
            state     <= IDLE;
            crc_valid <= 1'b0;
            s_ready   <= 1'b1;
            busy      <= 1'b0;
`ifdef CRC8_CHECK_EN
            crc_ok    <= 1'b0;
`endif
          end
        end
        default: begin
          state     <= IDLE;
          s_ready   <= 1'b1;
          crc_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifndef CRC8_CHECK_EN
  assign crc_ok = 1'b0;
`endif

endmodule
